uart_tx: RTL and testbench

Serial UART transmitter. It converts a parallel data word into an asynchronous frame: start bit, data bits LSB first, then stop bit(s). Bit timing comes from an external oversampling baud-tick generator at 16 ticks per bit, shared with the UART receiver. The block sits between the UART TX FIFO/controller and the serial `tx` pin.

---
 rtl/uart_tx.sv | 119 +++++++++++
 tb/tb_uart_tx.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// uart_tx -- serial UART transmitter.
//
// Turns a DBIT-wide word into an asynchronous frame: one start bit (low),
// DBIT data bits LSB first, then a stop period of SB_TICK baud ticks (high).
// Bit timing comes from an external 16x oversampling tick (s_tick).
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-high reset
//   tx_start     request to send din; only looked at while idle
//   s_tick       one-clk pulse at 16x the bit rate
//   din          word to send; captured when the request is accepted
//   tx_done_tick one-cycle pulse on the first idle cycle after the last stop tick
//   tx           serial line, registered, idles high
module uart_tx #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            tx_start,
  input  logic            s_tick,
  input  logic [DBIT-1:0] din,
  output logic            tx_done_tick,
  output logic            tx
);

  // Tick counter must reach both 15 (start/data bits) and SB_TICK-1 (stop).
  localparam int S_MAX = (SB_TICK - 1 > 15) ? SB_TICK - 1 : 15;
  localparam int SW    = $clog2(S_MAX + 1);
  localparam int NW    = (DBIT > 1) ? $clog2(DBIT) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state;
  logic [SW-1:0]   s;
  logic [NW-1:0]   n;
  logic [DBIT-1:0] b;
  logic [DBIT-1:0] b_nxt;

  // Shifted data word; its LSB is the next bit to put on the line, so tx can
  // be loaded at the same edge the shift happens and stay registered.
  always_comb begin
    b_nxt = b >> 1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      s            <= '0;
      n            <= '0;
      b            <= '0;
      tx           <= 1'b1;
      tx_done_tick <= 1'b0;
    end else begin
      tx_done_tick <= 1'b0;
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (tx_start) begin
            state <= START;
            s     <= '0;
            b     <= din;
            tx    <= 1'b0;  // start bit begins at the accepting edge
          end
        end

        START: begin
          if (s_tick) begin
            if (s == SW'(15)) begin
              state <= DATA;
              s     <= '0;
              n     <= '0;
              tx    <= b[0];
            end else begin
              s <= s + SW'(1);
            end
          end
        end

        DATA: begin
          if (s_tick) begin
            if (s == SW'(15)) begin
              s <= '0;
              b <= b_nxt;
              if (n == NW'(DBIT - 1)) begin
                state <= STOP;
                tx    <= 1'b1;
              end else begin
                n  <= n + NW'(1);
                tx <= b_nxt[0];
              end
            end else begin
              s <= s + SW'(1);
            end
          end
        end

        STOP: begin
          if (s_tick) begin
            if (s == SW'(SB_TICK - 1)) begin
              state        <= IDLE;
              tx_done_tick <= 1'b1;
              tx           <= 1'b1;
            end else begin
              s <= s + SW'(1);
            end
          end
        end

        default: begin
          state <= IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: a default instance (1 stop bit) and an SB_TICK=32
// instance (2 stop bits) share clock, reset, tick and data; tx_start is
// steered to one of them by sel. Expected line levels come from the frame
// definition: after k ticks of a frame the line carries bit k/16 of
// {start=0, data LSB first, stop=1}.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       tx_start = 1'b0;
  logic       s_tick = 1'b0;
  logic [7:0] din = 8'h00;
  logic       sel = 1'b0;

  logic tx_a, done_a, tx_b, done_b;
  logic tx_o, done_o;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  uart_tx #(.DBIT(8), .SB_TICK(16)) dut_a (
    .clk(clk), .reset(reset), .tx_start(tx_start & ~sel), .s_tick(s_tick),
    .din(din), .tx_done_tick(done_a), .tx(tx_a)
  );

  uart_tx #(.DBIT(8), .SB_TICK(32)) dut_b (
    .clk(clk), .reset(reset), .tx_start(tx_start & sel), .s_tick(s_tick),
    .din(din), .tx_done_tick(done_b), .tx(tx_b)
  );

  assign tx_o   = sel ? tx_b : tx_a;
  assign done_o = sel ? done_b : done_a;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are sampled there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: line level after k ticks of a frame carrying d.
  function automatic logic exp_line(input logic [7:0] d, input int k);
    int idx;
    idx = k / 16;
    if (idx == 0)      return 1'b0;
    else if (idx <= 8) return d[idx-1];
    else               return 1'b1;
  endfunction

  // Sends one frame with randomized idle gaps between ticks.
  //   lock_at : after this tick, pulse tx_start with 8'h3C (must be ignored)
  //   stall_at: after this tick, withhold s_tick for 100 cycles
  //   abort_at: after this tick, reset (together with a tick) and stop
  //   b2b     : leave the done cycle open for the caller to start the next frame
  task automatic run_frame(input logic [7:0] d, input int sb, input int lock_at,
                           input int stall_at, input int abort_at, input bit b2b);
    int total, gap;
    logic e;
    total = 16 + 16 * 8 + sb;
    sel = (sb == 32);
    din = d;
    tx_start = 1'b1;
    step();
    tx_start = 1'b0;
    chk("start_edge_tx", tx_o, 1'b0);
    chk("start_edge_done", done_o, 1'b0);
    din = $urandom;  // later din changes must not leak into the frame
    for (int k = 1; k <= total; k++) begin
      s_tick = 1'b1;
      step();
      s_tick = 1'b0;
      e = exp_line(d, k);
      chk($sformatf("tick%0d_tx", k), tx_o, e);
      chk($sformatf("tick%0d_done", k), done_o, (k == total));
      if (k == abort_at) begin
        reset = 1'b1;
        s_tick = 1'b1;
        step();
        reset = 1'b0;
        s_tick = 1'b0;
        chk("abort_tx", tx_o, 1'b1);
        chk("abort_done", done_o, 1'b0);
        for (int j = 0; j < 40; j++) begin
          s_tick = 1'b1;
          step();
          s_tick = 1'b0;
          step();
          chk("post_abort_tx", tx_o, 1'b1);
          chk("post_abort_done", done_o, 1'b0);
        end
        return;
      end
      if (k < total) begin
        if (k == lock_at) begin
          din = 8'h3C;
          tx_start = 1'b1;
          step();
          tx_start = 1'b0;
          chk("lock_tx", tx_o, e);
          chk("lock_done", done_o, 1'b0);
        end
        if (k == stall_at) begin
          for (int j = 0; j < 100; j++) step();
          chk("stall_tx", tx_o, e);
          chk("stall_done", done_o, 1'b0);
        end
        gap = $urandom_range(1, 3);
        for (int j = 0; j < gap; j++) step();
        chk("gap_tx", tx_o, e);
        chk("gap_done", done_o, 1'b0);
      end
    end
    if (!b2b) begin
      step();
      chk("after_done_done", done_o, 1'b0);
      chk("after_done_tx", tx_o, 1'b1);
    end
  endtask

  // Ticks run with no request: line must stay idle, no done pulse.
  task automatic idle_ticks(input int cnt, input string tag);
    for (int j = 0; j < cnt; j++) begin
      s_tick = 1'b1;
      step();
      s_tick = 1'b0;
      step();
    end
    chk({tag, "_tx_a"}, tx_a, 1'b1);
    chk({tag, "_tx_b"}, tx_b, 1'b1);
    chk({tag, "_done_a"}, done_a, 1'b0);
    chk({tag, "_done_b"}, done_b, 1'b0);
  endtask

  initial begin
    logic [7:0] r;
    // Reset
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("reset_tx_a", tx_a, 1'b1);
    chk("reset_done_a", done_a, 1'b0);
    chk("reset_tx_b", tx_b, 1'b1);
    chk("reset_done_b", done_b, 1'b0);
    idle_ticks(40, "idle");

    // Single frame A5
    run_frame(8'hA5, 16, -1, -1, -1, 1'b0);

    // Busy lockout: 3C requested mid-frame must be ignored
    run_frame(8'hA5, 16, 50, -1, -1, 1'b0);
    idle_ticks(200, "no_second_frame");

    // Back-to-back: 55 requested in the done cycle
    r = $urandom;
    run_frame(r, 16, -1, -1, -1, 1'b1);
    run_frame(8'h55, 16, -1, -1, -1, 1'b0);

    // Reset mid-frame (DATA bit 3), then a clean 00 frame
    run_frame(8'hFF, 16, -1, -1, 70, 1'b0);
    run_frame(8'h00, 16, -1, -1, -1, 1'b0);

    // Two stop bits with a mid-bit tick stall
    r = $urandom;
    run_frame(r, 32, -1, 37, -1, 1'b0);
    idle_ticks(20, "sb32_idle");

    // Random frames on both instances with random stall points
    for (int i = 0; i < 4; i++) begin
      r = $urandom;
      run_frame(r, (i % 2 == 0) ? 16 : 32, -1, $urandom_range(1, 150), -1, 1'b0);
    end

    // Simultaneous reset and tx_start: reset wins
    sel = 1'b0;
    reset = 1'b1;
    tx_start = 1'b1;
    din = 8'h00;
    step();
    reset = 1'b0;
    tx_start = 1'b0;
    chk("rst_vs_start_tx", tx_a, 1'b1);
    step();
    chk("rst_vs_start_tx2", tx_a, 1'b1);
    idle_ticks(20, "rst_vs_start_idle");

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
